// File: rtl/pwm_pkg.sv
// Shared defaults, FSM state encoding and frame-counter sizing for the PWM duty capture block.
package pwm_pkg;

    localparam int PERIOD_DEF = 256;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pwm_state_e;

    function automatic int fcnt_width(input int period);
        return (period < 2) ? 1 : $clog2(period);
    endfunction

    localparam int FCNT_W_DEF = fcnt_width(PERIOD_DEF);

endpackage

// File: rtl/pwm_high_counter.sv
// Saturating high-time counter for one PWM channel; clr has priority over inc.
// Latency: count updates on the edge after inc; no backpressure.
module pwm_high_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures R/G/B PWM high time over back-to-back PERIOD-cycle frames while en is high.
// Latency: results and valid register PERIOD edges after the frame's first sample; no backpressure.
module pwm_duty_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             R_in,
    input  logic             G_in,
    input  logic             B_in,
    output logic [CNT_W-1:0] R_time_out,
    output logic [CNT_W-1:0] G_time_out,
    output logic [CNT_W-1:0] B_time_out,
    output logic             valid,
    output logic             changed,
    output logic             busy
);

    localparam int            FW   = fcnt_width(PERIOD);
    localparam logic [FW-1:0] LAST = FW'(PERIOD - 1);

    pwm_state_e       state_q, state_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [2:0]       smp_q;
    logic [CNT_W-1:0] cnt   [3];
    logic [CNT_W-1:0] fin   [3];
    logic [CNT_W-1:0] out_q [3];
    logic [CNT_W-1:0] out_d [3];
    logic             have_prev_q, have_prev_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             clr;
    logic             publish;
    logic             diff;

    // Channel index 0/1/2 = R/G/B throughout.
    for (genvar i = 0; i < 3; i++) begin : g_ch
        pwm_high_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (smp_q[i]),
            .cnt (cnt[i])
        );
    end

    // Final count folds in the sample still sitting in smp_q on the completing cycle.
    always_comb begin
        diff = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fin[i] = cnt[i];
            if (smp_q[i] && (cnt[i] != '1)) begin
                fin[i] = cnt[i] + CNT_W'(1);
            end
            if (fin[i] != out_q[i]) begin
                diff = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        clr     = 1'b1;
        publish = 1'b0;
        case (state_q)
            IDLE: begin
                fcnt_d = '0;
                if (en) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else if (fcnt_q == LAST) begin
                    publish = 1'b1;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                    clr    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        valid_d     = publish;
        changed_d   = publish && have_prev_q && diff;
        have_prev_d = have_prev_q;
        if (state_q == IDLE) begin
            have_prev_d = 1'b0;
        end
        if (publish) begin
            have_prev_d = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            out_d[i] = publish ? fin[i] : out_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            smp_q       <= '0;
            have_prev_q <= 1'b0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            smp_q       <= {B_in, G_in, R_in};
            have_prev_q <= have_prev_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
            for (int i = 0; i < 3; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    assign R_time_out = out_q[0];
    assign G_time_out = out_q[1];
    assign B_time_out = out_q[2];
    assign valid      = valid_q;
    assign changed    = changed_q;
    assign busy       = (state_q == MEASURE);

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: frame-level reference model plus directed and random stimulus.
module tb_pwm_duty_capture;

    localparam int PERIOD = 256;
    localparam int CNT_W  = 8;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             en   = 1'b0;
    logic             R_in = 1'b0;
    logic             G_in = 1'b0;
    logic             B_in = 1'b0;
    logic [CNT_W-1:0] R_time_out, G_time_out, B_time_out;
    logic             valid, changed, busy;

    int checks  = 0;
    int errors  = 0;
    int edge_no = 0;
    int vld_edges[$];

    bit         m_active, m_have_prev;
    int         m_last[3];
    logic [2:0] m_frame[$];
    bit         exp_valid, exp_changed, exp_busy;

    bit f_valid, f_changed;
    int f_r, f_g, f_b, f_edge;

    pwm_duty_capture #(.PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .R_in       (R_in),
        .G_in       (G_in),
        .B_in       (B_in),
        .R_time_out (R_time_out),
        .G_time_out (G_time_out),
        .B_time_out (B_time_out),
        .valid      (valid),
        .changed    (changed),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: a frame is the PERIOD samples starting at the edge en is first seen high;
    // it is published at the following edge only if en is still high there.
    function automatic void model_reset();
        m_active    = 1'b0;
        m_have_prev = 1'b0;
        m_frame.delete();
        for (int c = 0; c < 3; c++) m_last[c] = 0;
        exp_valid   = 1'b0;
        exp_changed = 1'b0;
        exp_busy    = 1'b0;
    endfunction

    function automatic void model_edge(input logic e, input logic [2:0] s);
        int t[3];
        bit differs;
        exp_valid   = 1'b0;
        exp_changed = 1'b0;
        if (!m_active) begin
            if (e) begin
                m_active = 1'b1;
                m_frame.delete();
                m_frame.push_back(s);
            end
        end else if (!e) begin
            m_active    = 1'b0;
            m_have_prev = 1'b0;
        end else begin
            if (m_frame.size() == PERIOD) begin
                differs = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    t[c] = 0;
                    foreach (m_frame[k]) t[c] += int'(m_frame[k][c]);
                    if (t[c] > MAXV) t[c] = MAXV;
                    if (t[c] != m_last[c]) differs = 1'b1;
                end
                exp_valid   = 1'b1;
                exp_changed = m_have_prev && differs;
                m_last      = t;
                m_have_prev = 1'b1;
                m_frame.delete();
            end
            m_frame.push_back(s);
        end
        exp_busy = m_active;
    endfunction

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_edge(en, {B_in, G_in, R_in});
        end
    end

    initial begin : cmp
        forever begin
            @(negedge clk);
            check("valid",      32'(valid),      32'(exp_valid));
            check("changed",    32'(changed),    32'(exp_changed));
            check("busy",       32'(busy),       32'(exp_busy));
            check("R_time_out", 32'(R_time_out), 32'(m_last[0]));
            check("G_time_out", 32'(G_time_out), 32'(m_last[1]));
            check("B_time_out", 32'(B_time_out), 32'(m_last[2]));
            if (valid === 1'b1) vld_edges.push_back(edge_no + 1);
        end
    end

    initial begin : watchdog
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic drive(input logic e, input logic r, input logic g, input logic b);
        en   = e;
        R_in = r;
        G_in = g;
        B_in = b;
        @(posedge clk);
        #2;
    endtask

    // One frame with B high for frame cycles [blo,bhi); captures outputs after its first edge.
    task automatic frame(input logic r, input logic g, input int blo, input int bhi, input int abort_at);
        for (int j = 0; j < PERIOD; j++) begin
            if (j == abort_at) begin
                drive(1'b0, r, g, 1'b0);
                return;
            end
            drive(1'b1, r, g, (j >= blo && j < bhi));
            if (j == 0) begin
                f_valid   = valid;
                f_changed = changed;
                f_r       = int'(R_time_out);
                f_g       = int'(G_time_out);
                f_b       = int'(B_time_out);
                f_edge    = edge_no;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_R"},       32'(R_time_out), 32'd0);
        check({tag, "_G"},       32'(G_time_out), 32'd0);
        check({tag, "_B"},       32'(B_time_out), 32'd0);
        check({tag, "_valid"},   32'(valid),      32'd0);
        check({tag, "_changed"}, 32'(changed),    32'd0);
        check({tag, "_busy"},    32'(busy),       32'd0);
    endtask

    initial begin : main
        int s;
        int lat;
        int dens[3];
        logic e;

        #1 rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_zero_outputs("reset");
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);

        // R held high, G low, B high for the first 64 cycles of each frame.
        vld_edges.delete();
        frame(1'b1, 1'b0, 0, 64, -1);
        s = f_edge;
        frame(1'b1, 1'b0, 0, 64, -1);
        check("f1_valid",   32'(f_valid),   32'd1);
        check("f1_changed", 32'(f_changed), 32'd0);
        check("f1_R",       32'(f_r),       32'd255);
        check("f1_G",       32'(f_g),       32'd0);
        check("f1_B",       32'(f_b),       32'd64);
        lat = (vld_edges.size() > 0) ? vld_edges[0] - s : -1;
        check("first_latency", 32'(lat), 32'd257);

        frame(1'b1, 1'b0, 0, 128, -1);
        check("f2_valid",   32'(f_valid),   32'd1);
        check("f2_changed", 32'(f_changed), 32'd0);
        check("f2_B",       32'(f_b),       32'd64);
        lat = (vld_edges.size() > 1) ? vld_edges[1] - vld_edges[0] : -1;
        check("frame_interval", 32'(lat), 32'd256);

        // Publishes B=128, then en drops at frame cycle 100.
        frame(1'b1, 1'b0, 0, 128, 100);
        check("f3_valid",   32'(f_valid),   32'd1);
        check("f3_changed", 32'(f_changed), 32'd1);
        check("f3_B",       32'(f_b),       32'd128);
        check("abort_busy",  32'(busy),       32'd0);
        check("abort_valid", 32'(valid),      32'd0);
        check("abort_R",     32'(R_time_out), 32'd255);
        check("abort_B",     32'(B_time_out), 32'd128);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_no_valid", 32'(vld_edges.size()), 32'd3);

        vld_edges.delete();
        frame(1'b1, 1'b0, 0, 32, -1);
        s = f_edge;
        frame(1'b1, 1'b0, 0, 32, -1);
        check("restart_valid",   32'(f_valid),   32'd1);
        check("restart_changed", 32'(f_changed), 32'd0);
        check("restart_B",       32'(f_b),       32'd32);
        lat = (vld_edges.size() > 0) ? vld_edges[0] - s : -1;
        check("restart_latency", 32'(lat), 32'd257);

        // Reset pulse at frame cycle 150.
        for (int j = 0; j < 150; j++) drive(1'b1, 1'b1, 1'b0, (j < 32));
        rst = 1'b0;
        #1;
        check_zero_outputs("midrst");
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;

        vld_edges.delete();
        frame(1'b1, 1'b0, 0, 16, -1);
        s = f_edge;
        frame(1'b1, 1'b0, 255, 256, -1);
        check("postrst_valid",   32'(f_valid),   32'd1);
        check("postrst_changed", 32'(f_changed), 32'd0);
        check("postrst_R",       32'(f_r),       32'd255);
        check("postrst_B",       32'(f_b),       32'd16);
        lat = (vld_edges.size() > 0) ? vld_edges[0] - s : -1;
        check("postrst_latency", 32'(lat), 32'd257);

        frame(1'b1, 1'b0, 0, 1, -1);
        check("last_cycle_B",       32'(f_b),       32'd1);
        check("last_cycle_changed", 32'(f_changed), 32'd1);
        frame(1'b1, 1'b0, 0, 0, -1);
        check("first_cycle_B",       32'(f_b),       32'd1);
        check("first_cycle_changed", 32'(f_changed), 32'd0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Random densities, en toggling and occasional reset pulses.
        e = 1'b0;
        for (int c = 0; c < 3; c++) dens[c] = int'($urandom_range(0, 100));
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                for (int c = 0; c < 3; c++) begin
                    if ($urandom_range(0, 3) == 0) dens[c] = ($urandom_range(0, 1) == 0) ? 0 : 100;
                    else                           dens[c] = int'($urandom_range(0, 100));
                end
            end
            if (e) begin
                if ($urandom_range(0, 1499) == 0) e = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                e = 1'b1;
            end
            if ($urandom_range(0, 5999) == 0) begin
                rst = 1'b0;
                repeat (2) drive(e, 1'b0, 1'b0, 1'b0);
                rst = 1'b1;
            end
            drive(e,
                  int'($urandom_range(0, 99)) < dens[0],
                  int'($urandom_range(0, 99)) < dens[1],
                  int'($urandom_range(0, 99)) < dens[2]);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_capture.md
PWM_DUTY_CAPTURE -- requirements
Module: pwm_duty_capture

Interface
REQ-001 Parameter PERIOD, default 256: PWM frame length in clk cycles; SHALL be 2..65536.
REQ-002 Parameter CNT_W, default 8: width of each measured duty value.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  capture enable; high = measure frames continuously.
REQ-006 Port R_in / G_in / B_in  input  1 each  PWM waveforms to measure, synchronous to clk.
REQ-007 Port R_time_out / G_time_out / B_time_out  output  CNT_W each  last completed high-time per channel.
REQ-008 Port valid  output  1  one-cycle pulse when a frame result is written to the *_time_out ports.
REQ-009 Port changed  output  1  one-cycle pulse, coincident with valid, when the new triple differs from the previous one.
REQ-010 Port busy  output  1  high while the FSM is in MEASURE.

Function
REQ-011 R_in, G_in and B_in SHALL each be registered once. Counting SHALL use only the registered samples.
REQ-012 The FSM SHALL have states IDLE and MEASURE.
- IDLE->MEASURE when en=1 is sampled.
- MEASURE->IDLE when en=0 is sampled.
REQ-013 On IDLE->MEASURE, the frame counter and all three high counters SHALL clear to 0. The first sample is taken on the first MEASURE cycle.
REQ-014 In MEASURE, each cycle SHALL:
- increment the frame counter;
- increment each channel's high counter whose registered sample is 1.
REQ-015 High counters SHALL saturate at 2^CNT_W-1. For example, PERIOD=256 with the input held high SHALL yield 255.
REQ-016 When the frame counter equals PERIOD-1 and en=1, on the next edge the block SHALL:
- load all three *_time_out from the final counts, including that cycle's sample;
- pulse valid;
- clear the frame and high counters and start the next frame with no gap cycle.
REQ-017 changed SHALL compare against the previously loaded triple. It SHALL be 0 on the first valid after reset, and on the first valid after any return to IDLE.
REQ-018 en=0 mid-frame SHALL abort the frame: no valid, no changed, *_time_out unchanged, return to IDLE.
REQ-019 en=0 sampled on the frame-completing cycle (frame counter = PERIOD-1) SHALL also abort. Results are published only if en=1 on that cycle.
REQ-020 Latency: en first sampled high at edge N SHALL give valid at edge N+PERIOD+1, then every PERIOD cycles while en stays high.
REQ-021 busy SHALL equal (state==MEASURE).

Reset
REQ-022 rst=0 SHALL asynchronously force:
- state IDLE;
- all counters, sample registers and *_time_out to 0;
- valid, changed and busy to 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame. The first valid after release SHALL come from a complete new frame.

Structure
REQ-024 A shared package pwm_pkg SHALL hold:
- the PERIOD and CNT_W defaults;
- the state enumeration (IDLE, MEASURE);
- the frame-counter width, derived as clog2(PERIOD).
REQ-025 The saturating per-channel counter SHALL be a sub-module pwm_high_counter, instantiated three times. It has inputs clk, rst, clr, inc and output cnt.

Verification (PERIOD=256, CNT_W=8)
REQ-026 R_in held 1, G_in held 0, B_in high 64 of every 256 cycles, aligned with the frame start, en=1 -> first valid gives R=255, G=0, B=64, changed=0.
REQ-027 Same stimulus for a second frame -> valid exactly 256 cycles later, identical values, changed=0. Then B_in switched to 128 -> next valid gives B=128, changed=1.
REQ-028 en dropped at frame cycle 100 -> no valid, outputs hold the prior triple, busy falls. en raised again -> valid 257 cycles after the rising sample.
REQ-029 rst pulsed low at frame cycle 150 -> all outputs 0 immediately. With en=1 after release -> first valid after 257 cycles, from a full frame.
REQ-030 B_in high for only the final frame cycle (cycle 255) -> B=1. B_in high for only the first frame cycle (cycle 0) -> B=1. Both check for no off-by-one error.
